div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Multi-cycle RV32M divide/remainder unit for the execute stage. Accepts a decoded rv32_divop plus
//  operands over a valid/ready handshake, sequences an iterative restoring divider and returns
//  the quotient or remainder with the destination tag. Handles divide-by-zero, signed overflow and
//  pipeline flush. Serves one operation at a time.
// PARAMETERS
//  XLEN            32  operand/result width
//  BITS_PER_CYCLE  1   quotient bits per ITER cycle (1 or 2); XLEN % BITS_PER_CYCLE == 0
// PORTS
//  i_clk      in   1     clock
//  i_rst      in   1     synchronous, active-high reset
//  i_valid    in   1     request valid
//  o_ready    out  1     unit can accept a request (IDLE only)
//  i_divop    in   rv32_divop  divop_div/divu/rem/remu; divop_nop is never accepted
//  i_rs1      in   XLEN  dividend
//  i_rs2      in   XLEN  divisor
//  i_rd       in   5     destination tag, returned unchanged
//  i_flush    in   1     abort in-flight or pending op
//  o_valid    out  1     result valid
//  i_ready    in   1     consumer takes result
//  o_result   out  XLEN  quotient (div/divu) or remainder (rem/remu)
//  o_rd       out  5     tag of the result
//  o_busy     out  1     state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; o_valid=0, o_ready=1, o_busy=0, o_result=0, o_rd=0.
//  - Accept: i_valid && o_ready && i_divop!=divop_nop && !i_flush at edge k; divop, rd latched.
//  - FSM: IDLE -> PREP -> ITER -> FIX -> DONE -> IDLE.
//    PREP (k+1): signed ops take |rs1|,|rs2|, record quotient sign (s1^s2) and remainder sign (s1).
//      Special cases resolved here, skip straight to DONE:
//      rs2==0: quotient = all ones, remainder = rs1.
//      div/rem with rs1==-2^(XLEN-1), rs2==-1: quotient = rs1, remainder = 0.
//    ITER: XLEN/BITS_PER_CYCLE cycles; restoring step shifts {rem,quot} left, subtracts divisor
//      from the XLEN+1-bit partial remainder, sets the quotient bit when non-negative.
//    FIX: apply recorded signs (two's-complement negate), select quotient or remainder.
//    DONE: o_valid=1, o_result/o_rd stable until i_valid&&... i_ready; on i_ready -> IDLE.
//  - Latency (BPC=1, XLEN=32): normal o_valid first high at k+35; special case at k+2.
//  - No back-to-back overlap: o_ready low from k+1 until the cycle after the result handshake.
//  - i_flush: any state -> IDLE next edge, o_valid cleared, result discarded; flush with
//    simultaneous i_valid: request not accepted. Flush in DONE with i_ready: no result delivered.
//  - Unsigned ops use operands as-is; -2^(XLEN-1) magnitude held in XLEN bits unsigned (no wrap).
//  - i_rst mid-operation: state returns to IDLE, all outputs to reset values, next cycle o_ready=1.
// STRUCTURE
//  - types package: typedef enum div_state {div_idle, div_prep, div_iter, div_fix, div_done};
//    rv32_divop already present; add localparam DIV_TAG_W = 5.
//  - Sub-module div_iter_step: combinational single restoring step (rem_in, quot_in, divisor ->
//    rem_out, quot_out); instantiated BITS_PER_CYCLE times in a chain. FSM and sign logic in top.
// TESTING
//  - div 100/7, rd=5 -> o_valid at k+35, o_result=14, o_rd=5; rem same operands -> 2.
//  - div -7/2 -> 0xFFFFFFFD (-3); rem -7/2 -> 0xFFFFFFFF (-1); divu 0xFFFFFFFF/2 -> 0x7FFFFFFF.
//  - divu 5/0 -> 0xFFFFFFFF; remu 5/0 -> 5; div 0x80000000/-1 -> 0x80000000, rem -> 0; all at k+2.
//  - Hold i_ready=0 for 10 cycles in DONE -> o_valid, o_result stable; o_ready=0 throughout.
//  - i_flush at k+10 -> IDLE at k+11, o_valid never asserted, new request accepted at k+11.
//  - i_rst at k+20 -> outputs at reset values next cycle; i_valid with divop_nop -> never accepted.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared types for the RV32M divide unit: operation encoding, FSM states, tag width.
package div_unit_pkg;

  typedef enum logic [2:0] {
    divop_nop,
    divop_div,
    divop_divu,
    divop_rem,
    divop_remu
  } rv32_divop;

  typedef enum logic [2:0] {
    div_idle,
    div_prep,
    div_iter,
    div_fix,
    div_done
  } div_state;

  localparam int DIV_TAG_W = 5;

  function automatic logic is_signed_op(input rv32_divop op);
    return (op == divop_div) || (op == divop_rem);
  endfunction

  function automatic logic is_rem_op(input rv32_divop op);
    return (op == divop_rem) || (op == divop_remu);
  endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step: shift {rem,quot} left by one, keep the subtraction
// when the widened partial remainder is not below the divisor.
module div_iter_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quot_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quot_out
);

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            ge;

  // The remainder stays below the divisor, so after a successful subtract it fits XLEN bits.
  always_comb begin
    shifted  = {rem_in, quot_in[XLEN-1]};
    ge       = shifted >= {1'b0, divisor};
    diff     = shifted[XLEN-1:0] - divisor;
    rem_out  = ge ? diff : shifted[XLEN-1:0];
    quot_out = {quot_in[XLEN-2:0], ge};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divide/remainder unit: one op at a time, valid/ready on both sides,
// special cases resolved in PREP, signs applied in FIX.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  rv32_divop            i_divop,
  input  logic [XLEN-1:0]      i_rs1,
  input  logic [XLEN-1:0]      i_rs2,
  input  logic [DIV_TAG_W-1:0] i_rd,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [XLEN-1:0]      o_result,
  output logic [DIV_TAG_W-1:0] o_rd,
  output logic                 o_busy
);

  localparam int ITERS = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITERS) + 1;
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  div_state             state_q, state_d;
  rv32_divop            op_q, op_d;
  logic [DIV_TAG_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]      quot_q, quot_d;
  logic [XLEN-1:0]      rem_q, rem_d;
  logic [XLEN-1:0]      dvsr_q, dvsr_d;
  logic [XLEN-1:0]      result_q, result_d;
  logic                 neg_quot_q, neg_quot_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 accept, signed_op, s1, s2;
  logic [XLEN-1:0]      mag1, mag2, q_fix, r_fix;

  logic [BITS_PER_CYCLE:0][XLEN-1:0] rem_chain, quot_chain;

  assign rem_chain[0]  = rem_q;
  assign quot_chain[0] = quot_q;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    div_iter_step #(.XLEN(XLEN)) u_step (
      .rem_in  (rem_chain[g]),
      .quot_in (quot_chain[g]),
      .divisor (dvsr_q),
      .rem_out (rem_chain[g+1]),
      .quot_out(quot_chain[g+1])
    );
  end

  assign o_ready  = (state_q == div_idle);
  assign o_busy   = (state_q != div_idle);
  // Gated by flush so a flush coinciding with i_ready never completes a handshake.
  assign o_valid  = (state_q == div_done) && !i_flush;
  assign o_result = result_q;
  assign o_rd     = rd_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dvsr_d     = dvsr_q;
    result_d   = result_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    cnt_d      = cnt_q;

    accept    = i_valid && o_ready && (i_divop != divop_nop) && !i_flush;
    signed_op = is_signed_op(op_q);
    s1        = signed_op & quot_q[XLEN-1];
    s2        = signed_op & dvsr_q[XLEN-1];
    mag1      = s1 ? -quot_q : quot_q;
    mag2      = s2 ? -dvsr_q : dvsr_q;
    q_fix     = neg_quot_q ? -quot_q : quot_q;
    r_fix     = neg_rem_q ? -rem_q : rem_q;

    case (state_q)
      div_idle: begin
        if (accept) begin
          state_d = div_prep;
          op_d    = i_divop;
          rd_d    = i_rd;
          quot_d  = i_rs1;
          dvsr_d  = i_rs2;
        end
      end
      div_prep: begin
        if (dvsr_q == '0) begin
          result_d = is_rem_op(op_q) ? quot_q : ALL_ONES;
          state_d  = div_done;
        end else if (signed_op && quot_q == MIN_NEG && dvsr_q == ALL_ONES) begin
          result_d = is_rem_op(op_q) ? '0 : quot_q;
          state_d  = div_done;
        end else begin
          quot_d     = mag1;
          dvsr_d     = mag2;
          rem_d      = '0;
          cnt_d      = '0;
          neg_quot_d = s1 ^ s2;
          neg_rem_d  = s1;
          state_d    = div_iter;
        end
      end
      div_iter: begin
        quot_d = quot_chain[BITS_PER_CYCLE];
        rem_d  = rem_chain[BITS_PER_CYCLE];
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITERS - 1)) state_d = div_fix;
      end
      div_fix: begin
        result_d = is_rem_op(op_q) ? r_fix : q_fix;
        state_d  = div_done;
      end
      div_done: begin
        if (i_ready) state_d = div_idle;
      end
      default: state_d = div_idle;
    endcase

    if (i_flush) state_d = div_idle;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= div_idle;
      op_q       <= divop_nop;
      rd_q       <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      dvsr_q     <= '0;
      result_q   <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dvsr_q     <= dvsr_d;
      result_q   <= result_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Randomised and directed check of div_unit against a plain-arithmetic RV32M model.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst, i_valid, o_ready, i_flush, o_valid, i_ready, o_busy;
  rv32_divop   i_divop;
  logic [31:0] i_rs1, i_rs2, o_result;
  logic [4:0]  i_rd, o_rd;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  div_unit dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_divop(i_divop), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_rd(o_rd), .o_busy(o_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input rv32_divop op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    case (op)
      divop_divu: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      divop_remu: return (b == 0) ? a : a % b;
      divop_div:  return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      divop_rem:  return (b == 0) ? a : 32'(sa % sb);
      default:    return 32'h0;
    endcase
  endfunction

  function automatic int ref_lat(input rv32_divop op, input logic [31:0] a, input logic [31:0] b);
    logic sgn = (op == divop_div) || (op == divop_rem);
    if (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
    return 35;
  endfunction

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic issue(input rv32_divop op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    i_valid = 1'b1; i_divop = op; i_rs1 = a; i_rs2 = b; i_rd = rd;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0; i_divop = divop_nop; i_rs1 = $urandom; i_rs2 = $urandom;
    i_rd = 5'($urandom);
  endtask

  task automatic run_txn(input rv32_divop op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int hold);
    int          lat;
    logic        rdy_ok, stable;
    logic [31:0] r0;
    issue(op, a, b, rd);
    rdy_ok = 1'b1;
    lat    = 1;
    while (!o_valid && lat < 100) begin
      if (o_ready) rdy_ok = 1'b0;
      @(negedge i_clk);
      lat++;
    end
    chk("latency", lat, ref_lat(op, a, b));
    chk("result", o_result, ref_div(op, a, b));
    chk("rd", {27'b0, o_rd}, {27'b0, rd});
    r0     = o_result;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge i_clk);
      if (!o_valid || o_result !== r0 || o_rd !== rd || o_ready) stable = 1'b0;
    end
    chk("hold_stable", {31'b0, stable}, 32'd1);
    chk("ready_low_busy", {31'b0, rdy_ok}, 32'd1);
    i_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_ready = 1'b0;
    chk("after_hs", {30'b0, o_ready, o_valid}, 32'd2);
  endtask

  rv32_divop   d_op [9] = '{divop_div, divop_rem, divop_div, divop_rem, divop_divu,
                            divop_divu, divop_remu, divop_div, divop_rem};
  logic [31:0] d_a  [9] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF,
                            32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] d_b  [9] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd2,
                            32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  initial begin
    logic flag;
    i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
    i_divop = divop_nop; i_rs1 = '0; i_rs2 = '0; i_rd = '0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("reset_ctl", {29'b0, o_valid, o_ready, o_busy}, 32'd2);
    chk("reset_result", o_result, 32'd0);
    chk("reset_rd", {27'b0, o_rd}, 32'd0);

    for (int i = 0; i < 9; i++) run_txn(d_op[i], d_a[i], d_b[i], 5'd5, (i == 0) ? 10 : 0);

    // i_valid with nop is ignored
    flag = 1'b0;
    i_valid = 1'b1; i_divop = divop_nop; i_rs1 = 32'd9; i_rs2 = 32'd3;
    repeat (5) begin
      @(negedge i_clk);
      if (o_busy || o_valid) flag = 1'b1;
    end
    i_valid = 1'b0;
    chk("nop_ignored", {31'b0, flag}, 32'd0);

    // flush with simultaneous request: not accepted
    i_valid = 1'b1; i_divop = divop_div; i_rs1 = 32'd50; i_rs2 = 32'd5; i_flush = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0; i_flush = 1'b0;
    chk("flush_req_busy", {31'b0, o_busy}, 32'd0);

    // flush mid-iteration, then a new request straight away
    issue(divop_div, 32'd1000, 32'd3, 5'd7);
    flag = 1'b0;
    repeat (9) begin
      @(negedge i_clk);
      if (o_valid) flag = 1'b1;
    end
    i_flush = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_flush = 1'b0;
    chk("flush_no_valid", {31'b0, flag}, 32'd0);
    chk("flush_idle", {30'b0, o_ready, o_busy}, 32'd2);
    run_txn(divop_remu, 32'd1000, 32'd3, 5'd11, 1);

    // flush while DONE and consumer ready: nothing delivered
    issue(divop_divu, 32'd5, 32'd0, 5'd3);
    @(negedge i_clk);
    chk("done_before_flush", {31'b0, o_valid}, 32'd1);
    i_flush = 1'b1; i_ready = 1'b1;
    #1;
    chk("flush_done_valid", {31'b0, o_valid}, 32'd0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_flush = 1'b0; i_ready = 1'b0;
    chk("flush_done_idle", {29'b0, o_valid, o_ready, o_busy}, 32'd2);

    // randomised operations
    for (int n = 0; n < 40; n++) begin
      rv32_divop   op;
      logic [31:0] a, b;
      int          sel;
      op  = rv32_divop'(3'($urandom_range(1, 4)));
      sel = $urandom_range(0, 7);
      a   = $urandom;
      b   = $urandom;
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = $urandom_range(1, 20);
      else if (sel == 3) b = -$urandom_range(1, 20);
      run_txn(op, a, b, 5'($urandom), $urandom_range(0, 3));
    end

    // reset in the middle of an operation
    run_txn(divop_div, 32'd100, 32'd7, 5'd9, 0);
    issue(divop_div, 32'd12345, 32'd17, 5'd9);
    repeat (19) @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("rst_mid_ctl", {29'b0, o_valid, o_ready, o_busy}, 32'd2);
    chk("rst_mid_result", o_result, 32'd0);
    chk("rst_mid_rd", {27'b0, o_rd}, 32'd0);
    run_txn(divop_rem, 32'hFFFF_FFF9, 32'd2, 5'd1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
